// File: rtl/acc_act_lanes.sv
// Lock-step accumulate-and-activate engine: sums LANES signed partial-sum streams per pixel,
// then round-shifts, applies ReLU (leaky ReLU when ACC_ACT_LEAKY_EN is defined) and saturates.
module acc_act_lanes #(
    parameter int LANES  = 16,
    parameter int PSUM_W = 8,
    parameter int ACC_W  = 20,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int CH_W   = 6,
    parameter int SIZE_W = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_start_i,
    input  logic [SIZE_W-1:0]         cfg_ofmap_size_i,
    input  logic [CH_W-1:0]           cfg_ifmap_ch_i,
    input  logic [4:0]                cfg_shift_i,
    input  logic                      cfg_relu_en_i,
    input  logic [LANES*PSUM_W-1:0]   psum_i,
    input  logic                      psum_valid_i,
    output logic                      psum_ready_o,
    output logic                      act_valid_o,
    input  logic                      act_ready_i,
    output logic [LANES*DATA_W-1:0]   act_data_o,
    output logic [ADDR_W-1:0]         act_addr_o,
    output logic                      act_last_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int PIX_W = 2 * SIZE_W;
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (DATA_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]              state;
    logic [SIZE_W-1:0]       size_q;
    logic [CH_W-1:0]         ch_q;
    logic [4:0]              shift_q;
    logic                    relu_q;
    logic [CH_W-1:0]         ch_cnt;
    logic [PIX_W-1:0]        pix_cnt;
    logic [PIX_W-1:0]        pix_total;
    logic                    last_ch;
    logic                    last_pix;
    logic                    beat_acc;
    logic                    final_beat;
    logic signed [ACC_W:0]   rnd_inc;
    logic [LANES*DATA_W-1:0] act_next;

    assign pix_total  = PIX_W'(size_q) * PIX_W'(size_q);
    assign last_ch    = (ch_cnt == ch_q - CH_W'(1));
    assign last_pix   = (pix_cnt == pix_total - PIX_W'(1));
    assign beat_acc   = psum_valid_i && psum_ready_o;
    assign final_beat = beat_acc && last_ch;
    assign busy_o     = (state == ACCUM) || (state == DRAIN);

    // A final beat may only enter when the output register is free or draining this cycle.
    assign psum_ready_o = (state == ACCUM) && !(last_ch && act_valid_o && !act_ready_i);

    assign rnd_inc = (shift_q == 5'd0) ? '0 : ((ACC_W+1)'(1) << (shift_q - 5'd1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [PSUM_W-1:0] psum_l;
        logic signed [ACC_W-1:0]  acc_l;
        logic signed [ACC_W-1:0]  sum_l;
        logic signed [ACC_W:0]    biased_l;
        logic signed [ACC_W:0]    y_l;
        logic signed [ACC_W:0]    act_l;
        logic [DATA_W-1:0]        sat_l;

        assign psum_l   = psum_i[l*PSUM_W +: PSUM_W];
        // First channel of a pixel loads rather than adds, so no clear cycle is needed.
        assign sum_l    = ((ch_cnt == '0) ? '0 : acc_l)
                        + {{(ACC_W-PSUM_W){psum_l[PSUM_W-1]}}, psum_l};
        assign biased_l = {sum_l[ACC_W-1], sum_l} + rnd_inc;
        assign y_l      = biased_l >>> shift_q;

        always_comb begin
            act_l = y_l;
            if (relu_q && y_l[ACC_W]) begin
`ifdef ACC_ACT_LEAKY_EN
                act_l = y_l >>> 3;
`else
                act_l = '0;
`endif
            end
        end

        always_comb begin
            sat_l = act_l[DATA_W-1:0];
            if (act_l > SAT_MAX)
                sat_l = SAT_MAX[DATA_W-1:0];
            else if (act_l < SAT_MIN)
                sat_l = SAT_MIN[DATA_W-1:0];
        end

        assign act_next[l*DATA_W +: DATA_W] = sat_l;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                acc_l <= '0;
            else if (beat_acc)
                acc_l <= sum_l;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            size_q  <= '0;
            ch_q    <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            ch_cnt  <= '0;
            pix_cnt <= '0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start_i) begin
                        size_q  <= cfg_ofmap_size_i;
                        ch_q    <= (cfg_ifmap_ch_i == '0) ? CH_W'(1) : cfg_ifmap_ch_i;
                        shift_q <= cfg_shift_i;
                        relu_q  <= cfg_relu_en_i;
                        ch_cnt  <= '0;
                        pix_cnt <= '0;
                        if (cfg_ofmap_size_i == '0)
                            done_o <= 1'b1;
                        else
                            state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat_acc) begin
                        if (last_ch) begin
                            ch_cnt  <= '0;
                            pix_cnt <= pix_cnt + PIX_W'(1);
                            if (last_pix)
                                state <= DRAIN;
                        end else begin
                            ch_cnt <= ch_cnt + CH_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (act_valid_o && act_ready_i) begin
                        state  <= IDLE;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single output stage; contents are frozen while a result waits for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_valid_o <= 1'b0;
            act_data_o  <= '0;
            act_addr_o  <= '0;
            act_last_o  <= 1'b0;
        end else if (final_beat) begin
            act_valid_o <= 1'b1;
            act_data_o  <= act_next;
            act_addr_o  <= ADDR_W'(pix_cnt);
            act_last_o  <= last_pix;
        end else if (act_valid_o && act_ready_i) begin
            act_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_act_lanes.sv
// Directed bench for acc_act_lanes: single-pixel vector table plus multi-pixel,
// backpressure, reset and edge-config sequences. Expectations follow ACC_ACT_LEAKY_EN.
module tb_acc_act_lanes;

    localparam int LANES  = 16;
    localparam int PSUM_W = 8;
    localparam int ACC_W  = 20;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int CH_W   = 6;
    localparam int SIZE_W = 5;
    localparam int CW     = 160;
`ifdef ACC_ACT_LEAKY_EN
    localparam bit LEAKY = 1'b1;
`else
    localparam bit LEAKY = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    cfg_start_i = 1'b0;
    logic [SIZE_W-1:0]       cfg_ofmap_size_i = '0;
    logic [CH_W-1:0]         cfg_ifmap_ch_i = '0;
    logic [4:0]              cfg_shift_i = '0;
    logic                    cfg_relu_en_i = 1'b0;
    logic [LANES*PSUM_W-1:0] psum_i = '0;
    logic                    psum_valid_i = 1'b0;
    logic                    psum_ready_o;
    logic                    act_valid_o;
    logic                    act_ready_i = 1'b1;
    logic [LANES*DATA_W-1:0] act_data_o;
    logic [ADDR_W-1:0]       act_addr_o;
    logic                    act_last_o;
    logic                    busy_o;
    logic                    done_o;

    always #5 clk = ~clk;

    acc_act_lanes #(
        .LANES(LANES), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .DATA_W(DATA_W),
        .ADDR_W(ADDR_W), .CH_W(CH_W), .SIZE_W(SIZE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start_i(cfg_start_i),
        .cfg_ofmap_size_i(cfg_ofmap_size_i), .cfg_ifmap_ch_i(cfg_ifmap_ch_i),
        .cfg_shift_i(cfg_shift_i), .cfg_relu_en_i(cfg_relu_en_i),
        .psum_i(psum_i), .psum_valid_i(psum_valid_i), .psum_ready_o(psum_ready_o),
        .act_valid_o(act_valid_o), .act_ready_i(act_ready_i), .act_data_o(act_data_o),
        .act_addr_o(act_addr_o), .act_last_o(act_last_o), .busy_o(busy_o), .done_o(done_o)
    );

    typedef struct packed {
        int c; int shift; bit relu;
        int a0; int a1; int a2;
        int b0; int b1; int b2;
        int ea; int eb;
    } vec_t;

    typedef struct packed {
        logic [LANES*DATA_W-1:0] data;
        logic [ADDR_W-1:0]       addr;
        logic                    last;
    } out_t;

    int n_vec = 0;
    int n_err = 0;
    int beats_acc = 0;
    int done_cnt = 0;
    out_t out_q[$];
    logic [LANES*PSUM_W-1:0] beat_tab[$];
    vec_t vecs[8];

    // Handshakes are observed mid-cycle; they complete on the following rising edge.
    always @(negedge clk) begin
        if (psum_valid_i && psum_ready_o) beats_acc++;
        if (act_valid_o && act_ready_i) out_q.push_back('{act_data_o, act_addr_o, act_last_o});
        if (done_o) done_cnt++;
    end

    function automatic logic [LANES*PSUM_W-1:0] pack2(input int a, input int b);
        logic [LANES*PSUM_W-1:0] r;
        for (int l = 0; l < LANES; l++)
            r[l*PSUM_W +: PSUM_W] = (l % 2 == 0) ? a[PSUM_W-1:0] : b[PSUM_W-1:0];
        return r;
    endfunction

    task automatic check_output(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int s, input int c, input int sh, input bit relu);
        cfg_ofmap_size_i = s[SIZE_W-1:0];
        cfg_ifmap_ch_i   = c[CH_W-1:0];
        cfg_shift_i      = sh[4:0];
        cfg_relu_en_i    = relu;
        cfg_start_i      = 1'b1;
        tick();
        cfg_start_i      = 1'b0;
    endtask

    task automatic feed(input int total);
        int start = beats_acc;
        int guard = 0;
        while (beats_acc - start < total) begin
            if (guard > 200) begin
                n_vec++;
                n_err++;
                $display("[TB] FAIL feed_timeout: got %0d beats, expected %0d", beats_acc - start, total);
                break;
            end
            psum_valid_i = 1'b1;
            psum_i = beat_tab[(beats_acc - start) % beat_tab.size()];
            tick();
            guard++;
        end
        psum_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int n_out);
        for (int i = 0; i < 50; i++) begin
            if (done_cnt >= 1 && out_q.size() >= n_out) break;
            tick();
        end
        tick();
        tick();
    endtask

    task automatic apply_stimulus(input vec_t v);
        out_q.delete();
        beat_tab.delete();
        done_cnt = 0;
        beat_tab.push_back(pack2(v.a0, v.b0));
        beat_tab.push_back(pack2(v.a1, v.b1));
        beat_tab.push_back(pack2(v.a2, v.b2));
        start_job(1, v.c, v.shift, v.relu);
        feed((v.c == 0) ? 1 : v.c);
        wait_done(1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        out_t got;

        //          c  sh relu  a0    a1    a2    b0    b1    b2    ea                 eb
        vecs[0] = '{3, 0, 1'b0, 10,   20,   -5,   1,    2,    3,    25,                6};
        vecs[1] = '{2, 1, 1'b0, 127,  127,  0,    3,    0,    0,    127,               2};
        vecs[2] = '{2, 0, 1'b0, -128, -128, 0,    100,  100,  0,    -128,              127};
        vecs[3] = '{1, 0, 1'b1, -40,  0,    0,    50,   0,    0,    LEAKY ? -5 : 0,    50};
        vecs[4] = '{0, 0, 1'b0, 9,    0,    0,    -9,   0,    0,    9,                 -9};
        vecs[5] = '{2, 2, 1'b0, -3,   -2,   0,    5,    1,    0,    -1,                2};
        vecs[6] = '{3, 4, 1'b1, 127,  127,  127,  -100, -100, -100, 24,                LEAKY ? -3 : 0};
        vecs[7] = '{1, 0, 1'b1, -1,   0,    0,    0,    0,    0,    LEAKY ? -1 : 0,    0};

        tick();
        tick();
        check_output("reset_state",
                     {act_valid_o, act_data_o, act_addr_o, act_last_o, busy_o, done_o, psum_ready_o}, '0);
        rst_n = 1'b1;
        tick();

        // Four pixels of three channels each, consumer always ready.
        out_q.delete();
        done_cnt = 0;
        beat_tab = '{pack2(10, 10), pack2(20, 20), pack2(-5, -5)};
        start_job(2, 3, 0, 1'b0);
        feed(12);
        wait_done(4);
        check_output("multi_count", out_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            got = (i < out_q.size()) ? out_q[i] : '0;
            check_output("multi_data", got.data, pack2(25, 25));
            check_output("multi_addr_last", {got.addr, got.last}, {i[ADDR_W-1:0], i == 3});
        end
        check_output("multi_done", done_cnt, 1);

        for (int v = 0; v < 8; v++) begin
            apply_stimulus(vecs[v]);
            got = (out_q.size() > 0) ? out_q[0] : '0;
            check_output($sformatf("vec%0d_count", v), out_q.size(), 1);
            check_output($sformatf("vec%0d_data", v), got.data, pack2(vecs[v].ea, vecs[v].eb));
            check_output($sformatf("vec%0d_addr_last", v), {got.addr, got.last}, {{ADDR_W{1'b0}}, 1'b1});
            check_output($sformatf("vec%0d_done", v), done_cnt, 1);
        end

        // Consumer stalls for five cycles after the first result.
        out_q.delete();
        done_cnt = 0;
        beat_tab = '{pack2(1, 1), pack2(2, 2), pack2(3, 3), pack2(4, 4)};
        act_ready_i = 1'b0;
        start_job(2, 1, 0, 1'b0);
        fork
            feed(4);
            begin : bp_ctrl
                logic [LANES*DATA_W-1:0] held;
                int b0;
                for (int i = 0; i < 20 && !act_valid_o; i++) tick();
                held = act_data_o;
                b0 = beats_acc;
                check_output("bp_first", held, pack2(1, 1));
                for (int i = 0; i < 5; i++) begin
                    tick();
                    check_output("bp_hold", {act_valid_o, act_data_o, act_addr_o}, {1'b1, held, {ADDR_W{1'b0}}});
                end
                check_output("bp_extra_beats", (beats_acc - b0) <= 1, 1);
                act_ready_i = 1'b1;
            end
        join
        wait_done(4);
        check_output("bp_count", out_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            got = (i < out_q.size()) ? out_q[i] : '0;
            check_output("bp_data", got.data, pack2(i + 1, i + 1));
            check_output("bp_addr_last", {got.addr, got.last}, {i[ADDR_W-1:0], i == 3});
        end
        check_output("bp_done", done_cnt, 1);

        // Reset in the middle of a four-pixel job, then a fresh one-pixel job.
        out_q.delete();
        done_cnt = 0;
        beat_tab = '{pack2(5, 6)};
        act_ready_i = 1'b1;
        start_job(2, 1, 0, 1'b0);
        feed(2);
        act_ready_i = 1'b0;
        check_output("rst_pre", {act_valid_o, act_addr_o, busy_o}, {1'b1, ADDR_W'(1), 1'b1});
        rst_n = 1'b0;
        #1;
        check_output("rst_mid",
                     {act_valid_o, act_data_o, act_addr_o, act_last_o, busy_o, done_o, psum_ready_o}, '0);
        tick();
        rst_n = 1'b1;
        tick();
        out_q.delete();
        done_cnt = 0;
        beat_tab = '{pack2(7, 7)};
        act_ready_i = 1'b1;
        start_job(1, 1, 0, 1'b0);
        feed(1);
        wait_done(1);
        got = (out_q.size() > 0) ? out_q[0] : '0;
        check_output("rst_new_count", out_q.size(), 1);
        check_output("rst_new_data", got.data, pack2(7, 7));
        check_output("rst_new_addr_last", {got.addr, got.last}, {{ADDR_W{1'b0}}, 1'b1});
        check_output("rst_new_done", done_cnt, 1);

        // Zero-size job: a done pulse and nothing else.
        out_q.delete();
        done_cnt = 0;
        start_job(0, 1, 0, 1'b0);
        repeat (4) tick();
        check_output("s0_done", done_cnt, 1);
        check_output("s0_no_output", out_q.size(), 0);
        check_output("s0_idle", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
